decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 181 ++++++++++++++++++
 tb/tb_decode_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue
//   Small FIFO of decoded instructions. Each fetched 16-bit instruction is
//   decoded as it is written, and the entry holds only the decoded fields.
//   The head entry drives the out_* fields. They read as zero whenever the
//   queue is empty.
//
// Optional feature macro: DECODE_ILLEGAL_DETECT_EN
//   When defined, each entry also carries an illegal-encoding flag, which is
//   presented on out_illegal.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 discard every queued entry at the next edge
//   in_valid/in_ready     push handshake; in_ready is high while count < DEPTH
//   in_instr[15:0]        fetched instruction
//   out_valid/out_ready   pop handshake; out_valid is high while count > 0
//   out_opcode, out_op, out_alu_op, out_shift, out_cond   decoded head fields
//   out_rd, out_rn, out_rm                                register indices
//   out_sximm5, out_sximm8                                sign-extended immediates
//   out_illegal           illegal-encoding flag (feature macro only)
//   count                 number of occupied entries
module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 16,
  parameter int N_REGISTER = 8,
  localparam int REG_W     = $clog2(N_REGISTER),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [1:0]        out_op,
  output logic [1:0]        out_alu_op,
  output logic [1:0]        out_shift,
  output logic [2:0]        out_cond,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rn,
  output logic [REG_W-1:0]  out_rm,
  output logic [DATA_W-1:0] out_sximm5,
  output logic [DATA_W-1:0] out_sximm8,
`ifdef DECODE_ILLEGAL_DETECT_EN
  output logic              out_illegal,
`endif
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [1:0]        shift;
    logic [2:0]        cond;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;
`ifdef DECODE_ILLEGAL_DETECT_EN
    logic              illegal;
`endif
  } entry_t;

  // A 3-bit register field is truncated when REG_W < 3 and zero-extended
  // when REG_W > 3.
  function automatic logic [REG_W-1:0] reg_field(input logic [2:0] f);
    return REG_W'(f);
  endfunction

  function automatic entry_t decode(input logic [15:0] instr);
    entry_t     e;
    logic [4:0] key;
    e   = '0;
    key = instr[15:11];
    e.opcode = instr[15:13];
    e.op     = instr[12:11];
    e.cond   = instr[10:8];
    e.rn     = reg_field(instr[10:8]);
    e.rm     = reg_field(instr[2:0]);
    // These two encodings take their destination from the rn slot.
    if (key == 5'b11010 || key == 5'b01011) begin
      e.rd = reg_field(instr[10:8]);
    end else begin
      e.rd = reg_field(instr[7:5]);
    end
    if (instr[15:13] == 3'b100) begin
      e.shift = 2'b00;
    end else begin
      e.shift = instr[4:3];
    end
    e.sximm5 = {{(DATA_W-5){instr[4]}}, instr[4:0]};
    e.sximm8 = {{(DATA_W-8){instr[7]}}, instr[7:0]};
`ifdef DECODE_ILLEGAL_DETECT_EN
    case (key)
      5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b01100,
      5'b10000, 5'b00100, 5'b01011, 5'b01000, 5'b01010, 5'b11100:
        e.illegal = 1'b0;
      default:
        e.illegal = 1'b1;
    endcase
`endif
    return e;
  endfunction

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;
  entry_t             head_s;

  assign in_ready  = (count_r < CNT_W'(DEPTH));
  assign out_valid = (count_r != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign count     = count_r;

  // Pointer and occupancy state. Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. It is never reset, because the outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= decode(in_instr);
    end
  end

  // Head selection. While the queue is empty, every field reads as zero.
  always_comb begin
    head_s = '0;
    if (out_valid) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_opcode = head_s.opcode;
  assign out_op     = head_s.op;
  assign out_alu_op = head_s.op;
  assign out_shift  = head_s.shift;
  assign out_cond   = head_s.cond;
  assign out_rd     = head_s.rd;
  assign out_rn     = head_s.rn;
  assign out_rm     = head_s.rm;
  assign out_sximm5 = head_s.sximm5;
  assign out_sximm8 = head_s.sximm8;
`ifdef DECODE_ILLEGAL_DETECT_EN
  assign out_illegal = head_s.illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Directed bench for decode_queue with the default parameters. A queue of
//   raw instructions models the FIFO. Expected head fields are decoded from
//   the raw head instruction using the field rules. Literal pins anchor the
//   model on the worked example instructions.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [1:0]  out_op;
  logic [1:0]  out_alu_op;
  logic [1:0]  out_shift;
  logic [2:0]  out_cond;
  logic [2:0]  out_rd;
  logic [2:0]  out_rn;
  logic [2:0]  out_rm;
  logic [15:0] out_sximm5;
  logic [15:0] out_sximm8;
  logic [2:0]  count;
`ifdef DECODE_ILLEGAL_DETECT_EN
  logic        out_illegal;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op(out_op), .out_alu_op(out_alu_op),
    .out_shift(out_shift), .out_cond(out_cond),
    .out_rd(out_rd), .out_rn(out_rn), .out_rm(out_rm),
    .out_sximm5(out_sximm5), .out_sximm8(out_sximm8),
`ifdef DECODE_ILLEGAL_DETECT_EN
    .out_illegal(out_illegal),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected head fields, packed as
  // {opcode, op, alu_op, shift, cond, rd, rn, rm, sximm5, sximm8}.
  function automatic logic [52:0] exp_fields(input logic [15:0] i);
    logic [4:0]  key;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [15:0] s5;
    logic [15:0] s8;
    key = i[15:11];
    rd  = (key == 5'b11010 || key == 5'b01011) ? i[10:8] : i[7:5];
    sh  = (i[15:13] == 3'b100) ? 2'b00 : i[4:3];
    s5  = 16'($signed(i[4:0]));
    s8  = 16'($signed(i[7:0]));
    return {i[15:13], i[12:11], i[12:11], sh, i[10:8], rd, i[10:8], i[2:0], s5, s8};
  endfunction

  function automatic logic exp_illegal(input logic [15:0] i);
    logic [4:0] key;
    key = i[15:11];
    return !(key inside {5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110,
                         5'b10111, 5'b01100, 5'b10000, 5'b00100, 5'b01011,
                         5'b01000, 5'b01010, 5'b11100});
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check(input string tag);
    logic [52:0] e;
    e = (q.size() > 0) ? exp_fields(q[0]) : 53'd0;
    cmp({tag, ".count"}, 64'(count), 64'(q.size()));
    cmp({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    cmp({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    cmp({tag, ".fields"},
        64'({out_opcode, out_op, out_alu_op, out_shift, out_cond, out_rd,
             out_rn, out_rm, out_sximm5, out_sximm8}), 64'(e));
`ifdef DECODE_ILLEGAL_DETECT_EN
    cmp({tag, ".out_illegal"}, 64'(out_illegal),
        64'((q.size() > 0) ? exp_illegal(q[0]) : 1'b0));
`endif
  endtask

  // Apply one cycle of inputs, update the model at the edge, then check at the falling edge.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic r, input logic f);
    bit push;
    bit pop;
    in_valid = v; in_instr = ins; out_ready = r; flush = f;
    push = v && (q.size() < DEPTH);
    pop  = (q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ins);
    end
    @(negedge clk);
    check("cyc");
  endtask

  logic [15:0] fill [5] = '{16'h2A41, 16'h5B93, 16'h7C2E, 16'h4D05, 16'h9E77};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b0;
    #1;
    check("reset");
    cmp("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Worked decode examples.
    cycle(1'b1, 16'hD2F5, 1'b0, 1'b0);
    cmp("d2f5.out_valid", 64'(out_valid), 64'd1);
    cmp("d2f5.opcode", 64'(out_opcode), 64'(3'b110));
    cmp("d2f5.op", 64'(out_op), 64'(2'b10));
    cmp("d2f5.rd", 64'(out_rd), 64'(3'd2));
    cmp("d2f5.rn", 64'(out_rn), 64'(3'd2));
    cmp("d2f5.sximm8", 64'(out_sximm8), 64'(16'hFFF5));
    cmp("d2f5.count", 64'(count), 64'd1);
    cycle(1'b1, 16'hB168, 1'b1, 1'b0);
    cmp("b168.out_valid", 64'(out_valid), 64'd1);
    cmp("b168.count", 64'(count), 64'd1);
    cmp("b168.rd", 64'(out_rd), 64'(3'd3));
    cmp("b168.rn", 64'(out_rn), 64'(3'd1));
    cmp("b168.rm", 64'(out_rm), 64'(3'd0));
    cmp("b168.shift", 64'(out_shift), 64'(2'b01));
    cmp("b168.alu_op", 64'(out_alu_op), 64'(2'b10));
    cmp("b168.sximm5", 64'(out_sximm5), 64'(16'h0008));
    cycle(1'b1, 16'h8218, 1'b1, 1'b0);
    cmp("8218.shift", 64'(out_shift), 64'(2'b00));
    cmp("8218.rd", 64'(out_rd), 64'(3'd0));
    cmp("8218.rn", 64'(out_rn), 64'(3'd2));
    cmp("8218.sximm5", 64'(out_sximm5), 64'(16'hFFF8));
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cmp("drain.out_valid", 64'(out_valid), 64'd0);

`ifdef DECODE_ILLEGAL_DETECT_EN
    cycle(1'b1, 16'hE800, 1'b0, 1'b0);
    cmp("e800.illegal", 64'(out_illegal), 64'd1);
    cycle(1'b1, 16'hE000, 1'b1, 1'b0);
    cmp("e000.illegal", 64'(out_illegal), 64'd0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    // Fill to full, try a fifth push, then stream across the pointer wrap.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, fill[k], 1'b0, 1'b0);
      if (k == 3) cmp("full.in_ready", 64'(in_ready), 64'd0);
    end
    cmp("full.count", 64'(count), 64'd4);
    cmp("full.head_sximm8", 64'(out_sximm8), 64'(16'h0041));
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 16'h6000 + 16'(k) * 16'h0123, 1'b1, 1'b0);
      if (k == 0) cmp("wrap.head_sximm8", 64'(out_sximm8), 64'(16'hFF93));
    end
    for (int k = 0; k < 5; k++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cmp("wrap.empty", 64'(count), 64'd0);

    // Flush with a same-cycle push and pop.
    for (int k = 0; k < 3; k++) cycle(1'b1, fill[k+1], 1'b0, 1'b0);
    cmp("preflush.count", 64'(count), 64'd3);
    cycle(1'b1, 16'hC3C3, 1'b1, 1'b1);
    cmp("flush.count", 64'(count), 64'd0);
    cmp("flush.out_valid", 64'(out_valid), 64'd0);
    cmp("flush.sximm8", 64'(out_sximm8), 64'd0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("midreset");
    cmp("midreset.count", 64'(count), 64'd0);
    cmp("midreset.rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    check("inreset");
    rst_n = 1'b1;
    cycle(1'b1, 16'h4321, 1'b0, 1'b0);

    // Mixed traffic with random instructions and a flush.
    for (int k = 0; k < 40; k++) begin
      cycle((k % 3) != 0, 16'($urandom), (k % 4) < 2, k == 25);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
